// File: rtl/uart_tx_multi.sv
// uart_tx_multi: FIFO-fed UART transmitter, 5..MaxDataBits data bits, optional parity, 1/1.5/2 stop bits.
// Optional flow control: define UART_TX_MULTI_CTS_EN to add the active-low cts_ni input.
module uart_tx_multi #(
  parameter int MaxDataBits = 9,
  parameter int FifoDepth   = 16,
  parameter int UsageW      = $clog2(FifoDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tick_i,
  input  logic [3:0]             cfg_data_bits_i,
  input  logic                   cfg_par_en_i,
  input  logic [1:0]             cfg_par_mode_i,
  input  logic [1:0]             cfg_stop_i,
  input  logic                   cfg_break_i,
  input  logic [UsageW-1:0]      cfg_watermark_i,
  input  logic                   flush_i,
`ifdef UART_TX_MULTI_CTS_EN
  input  logic                   cts_ni,
`endif
  input  logic [MaxDataBits-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   txd_o,
  output logic                   busy_o,
  output logic                   empty_o,
  output logic [UsageW-1:0]      fifo_usage_o,
  output logic                   watermark_o
);

  localparam int                AddrW     = $clog2(FifoDepth);
  localparam logic [3:0]        MinBits   = 4'd5;
  localparam logic [3:0]        MaxBits   = 4'(MaxDataBits);
  localparam logic [UsageW-1:0] FullLevel = UsageW'(FifoDepth);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- FIFO ----------------
  logic [MaxDataBits-1:0] fifo_mem [FifoDepth];
  logic [AddrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [UsageW-1:0]      usage_q;
  logic                   fifo_full, fifo_empty, push, pop;
  logic [MaxDataBits-1:0] head;

  assign fifo_full  = (usage_q == FullLevel);
  assign fifo_empty = (usage_q == '0);
  assign push       = valid_i & ~fifo_full & ~flush_i;
  assign head       = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({push, pop})
        2'b10:   usage_q <= usage_q + UsageW'(1);
        2'b01:   usage_q <= usage_q - UsageW'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  // ---------------- frame configuration ----------------
  logic [3:0]             nbits_cfg;
  logic [MaxDataBits-1:0] data_mask;
  logic [MaxDataBits-1:0] head_masked;
  logic                   par_calc;

  always_comb begin
    nbits_cfg = cfg_data_bits_i;
    if (cfg_data_bits_i < MinBits)      nbits_cfg = MinBits;
    else if (cfg_data_bits_i > MaxBits) nbits_cfg = MaxBits;
  end

  for (genvar gi = 0; gi < MaxDataBits; gi++) begin : g_mask
    assign data_mask[gi] = (nbits_cfg > 4'(gi));
  end

  assign head_masked = head & data_mask;

  always_comb begin
    case (cfg_par_mode_i)
      2'b00:   par_calc = ~^head_masked;
      2'b01:   par_calc = ^head_masked;
      2'b10:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  // Clear-to-send gate; only consulted when a new frame would begin.
  logic cts_ok;
`ifdef UART_TX_MULTI_CTS_EN
  assign cts_ok = ~cts_ni;
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------- transmit FSM ----------------
  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d, bit_limit;
  logic [3:0]             idx_q, idx_d;
  logic [MaxDataBits-1:0] shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic [3:0]             nbits_q;
  logic                   par_en_q, par_bit_q;
  logic [1:0]             stop_q;
  logic                   can_start, bit_end, load;

  assign can_start = tick_i & ~fifo_empty & cts_ok;

  always_comb begin
    bit_limit = 5'd15;
    if (state_q == S_STOP) begin
      case (stop_q)
        2'b00:   bit_limit = 5'd15;
        2'b01:   bit_limit = 5'd23;
        default: bit_limit = 5'd31;
      endcase
    end
  end

  assign bit_end = tick_i & (cnt_q == bit_limit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    load    = 1'b0;
    if (tick_i) cnt_d = bit_end ? 5'd0 : cnt_q + 5'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = 5'd0;
        txd_d = 1'b1;
        if (can_start) begin
          load    = 1'b1;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 4'd0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            txd_d   = par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain the next frame directly when data is waiting.
          if (can_start) begin
            load    = 1'b1;
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    if (load) shift_d = head_masked;
  end

  assign pop = load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      nbits_q   <= MinBits;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (load) begin
        nbits_q   <= nbits_cfg;
        par_en_q  <= cfg_par_en_i;
        par_bit_q <= par_calc;
        stop_q    <= cfg_stop_i;
      end
    end
  end

  assign txd_o        = txd_q & ~cfg_break_i;
  assign busy_o       = (state_q != S_IDLE);
  assign empty_o      = fifo_empty & (state_q == S_IDLE);
  assign ready_o      = ~fifo_full;
  assign fifo_usage_o = usage_q;
  assign watermark_o  = (usage_q <= cfg_watermark_i);

endmodule

// File: doc/uart_tx_multi.md
Name: uart_tx_multi

Overview:
- Parametrised next-generation UART transmitter for the UART peripheral.
- Provides a valid/ready byte interface into an internal FIFO of configurable depth.
- Frames data from 5 up to MaxDataBits bits, with optional parity and 1, 1.5 or 2 stop bits.
- Bit timing comes from an external oversampling tick: 16 ticks per bit. This allows fractional stop bits and deterministic frame lengths.

Parameters:
- MaxDataBits, 9: widest supported data word (5..9); sets the width of data_i.
- FifoDepth, 16: TX FIFO entries; power of two, at least 2.
- UsageW, $clog2(FifoDepth+1): width of the usage and watermark fields (derived, do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- tick_i  in  1  oversampling strobe, 16 per bit period, single-cycle pulse
- cfg_data_bits_i  in  4  data bits per frame; values <5 clamp to 5, values >MaxDataBits clamp to MaxDataBits
- cfg_par_en_i  in  1  parity bit enable
- cfg_par_mode_i  in  2  00 odd, 01 even, 10 forced 1, 11 forced 0
- cfg_stop_i  in  2  00 one stop bit, 01 1.5 stop bits, 10/11 two stop bits
- cfg_break_i  in  1  force the line low
- cfg_watermark_i  in  UsageW  low-watermark threshold
- flush_i  in  1  synchronous FIFO clear
- data_i  in  MaxDataBits  word to push into the FIFO
- valid_i  in  1  push request
- ready_o  out  1  FIFO not full
- txd_o  out  1  serial output
- busy_o  out  1  frame in progress (state not IDLE)
- empty_o  out  1  FIFO empty and state IDLE
- fifo_usage_o  out  UsageW  FIFO fill level
- watermark_o  out  1  fifo_usage_o <= cfg_watermark_i

Behaviour:
- Reset (async, rst_ni low):
  - FIFO empty, state IDLE, tick counter 0, txd register 1.
  - Outputs: txd_o=1, ready_o=1, busy_o=0, empty_o=1, fifo_usage_o=0, watermark_o=1.
- FIFO:
  - Push on valid_i & ready_o; ready_o = ~full.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - No fall-through: a word pushed in cycle N can be popped no earlier than N+1.
  - Simultaneous push and pop leave usage unchanged.
  - flush_i empties the FIFO next cycle and overrides a same-cycle push. It does not abort the frame in flight.
- txd_o = txd_q & ~cfg_break_i.
  - Break does not stall the state machine; frames continue underneath.
- States: IDLE, START, DATA, PARITY, STOP.
  - A 5-bit counter increments on tick_i.
  - A state/bit ends at the tick where the counter reaches its limit:
    - 15 for START, DATA and PARITY bits;
    - 15 / 23 / 31 for the 1 / 1.5 / 2 stop-bit settings.
  - The counter resets to 0 on each bit boundary.
- IDLE:
  - On tick_i with FIFO non-empty: pop, load the shift register with the word masked to the data bits, latch the configuration into shadow registers, go to START.
  - txd_q = 0 from the next cycle.
  - Configuration changes mid-frame have no effect on the current frame.
- START: drive 0 for 16 ticks, then go to DATA with bit index 0.
- DATA:
  - Drive LSB first, one bit per 16 ticks.
  - After the last data bit, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Odd: ~^data. Even: ^data. Computed over the masked data bits only.
  - Forced modes drive 1 or 0.
  - Lasts 16 ticks, then go to STOP.
- STOP:
  - Drive 1 for 16, 24 or 32 ticks.
  - At the end, if the FIFO is non-empty: pop and go straight to START (back-to-back, no idle gap). Otherwise go to IDLE.
- txd_q updates on the same clock edge as the state change and is visible on txd_o the following cycle.
- Frame length in ticks: 16 × (1 + data bits + parity) + stop ticks.
- busy_o is high from the cycle after the pop until the cycle after STOP ends (if no next frame follows).
- Bit counter and shift register are wide enough for MaxDataBits; no wrap-around within a frame.

Optional Feature:
- Macro UART_TX_MULTI_CTS_EN.
- Defined:
  - Adds input cts_ni (1 bit, active low, already synchronised upstream).
  - A new frame is started from IDLE, or back-to-back from STOP, only when cts_ni=0. Otherwise the block waits in IDLE with txd=1.
  - Deasserting CTS mid-frame never truncates the frame.
- Not defined: the port is absent and transmission is never gated.

Test Plan:
- tick_i every cycle, 8N1, push 0xA5:
  - txd_o = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles (160 cycles total).
  - busy_o then drops and empty_o=1.
- 9 data bits, even parity, 2 stop bits, push 0x1FF:
  - 9 ones, then parity 1, then stop high for 32 ticks.
  - Frame = 208 ticks.
- 5 data bits, odd parity, 1.5 stop bits, push 0xFF:
  - Data 11111, parity 0, stop high for 24 ticks.
  - Upper data bits masked.
- Push 16 words (FifoDepth=16) with no ticks:
  - ready_o=0 at usage 16; a 17th push is refused.
  - With cfg_watermark_i=4, watermark_o rises when usage drops to 4.
  - With ticks enabled, frames run back-to-back with no idle gap.
- Push 3 words, assert flush_i mid-frame 1:
  - Frame 1 completes intact; usage becomes 0; no further frames.
  - cfg_break_i=1 holds txd_o=0 throughout.
- With UART_TX_MULTI_CTS_EN, cts_ni=1 and 2 words pushed:
  - txd_o stays 1 and the FIFO is unchanged.
  - Setting cts_ni=0 starts transmission on the next tick.
  - Raising cts_ni mid-frame completes the frame, then the block holds in IDLE.
